// File: rtl/reorder_buffer_pkg.sv
// Shared types and sizing for the reorder buffer: writeback lane format,
// retirement trace packet and the per-entry storage record.
package reorder_buffer_pkg;

   localparam int ROB_DEPTH = 16;
   localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
   localparam int CDB_SIZE  = 3;
   localparam int PREG_W    = 6;

   typedef struct packed {
      logic [31:0] insn;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
   } rvfi_t;

   typedef struct packed {
      logic                 valid;
      logic [ROB_IDX_W-1:0] ROB_entry;
      logic [31:0]          rd_data;
      logic [31:0]          pc_wdata;
      logic                 flush;
   } CDB_t;

   typedef struct packed {
      logic              valid;
      logic              done;
      logic              flush;
      logic [4:0]        rd_addr;
      logic [PREG_W-1:0] rd_paddr;
      logic [31:0]       pc_wdata;
      rvfi_t             rvfi;
   } rob_entry_t;

   function automatic logic [ROB_IDX_W:0] ptr_inc(input logic [ROB_IDX_W:0] p);
      return p + 1'b1;
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates at the tail on dispatch, marks entries done
// from the writeback lanes, and retires one head entry per cycle with flush redirect.
module reorder_buffer
   import reorder_buffer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 dispatch_valid,
   input  logic [4:0]           dispatch_rd_addr,
   input  logic [PREG_W-1:0]    dispatch_rd_paddr,
   input  rvfi_t                dispatch_rvfi,
   output logic                 dispatch_ready,
   output logic [ROB_IDX_W-1:0] dispatch_rob_entry,
   input  CDB_t                 WB_Bus [CDB_SIZE],
   output logic                 commit_valid,
   output logic [4:0]           commit_rd_addr,
   output logic [PREG_W-1:0]    commit_rd_paddr,
   output logic [ROB_IDX_W-1:0] commit_rob_entry,
   output rvfi_t                commit_rvfi,
   output logic                 flush,
   output logic [31:0]          flush_pc,
   output logic                 rob_empty
);

   rob_entry_t           entry_reg [ROB_DEPTH];
   logic [ROB_IDX_W:0]   head_reg;
   logic [ROB_IDX_W:0]   tail_reg;
   logic [ROB_IDX_W-1:0] head_idx;
   logic [ROB_IDX_W-1:0] tail_idx;
   logic                 full;
   logic                 dispatch_fire;
   logic                 commit_int;
   logic                 flush_int;
   rob_entry_t           head_entry;

   // lane_match[e][l]: lane l is writing back to entry e this cycle
   logic [ROB_DEPTH-1:0][CDB_SIZE-1:0] lane_match;

   for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      for (genvar gl = 0; gl < CDB_SIZE; gl++) begin : g_lane
         assign lane_match[gi][gl] = WB_Bus[gl].valid &&
                                     (WB_Bus[gl].ROB_entry == ROB_IDX_W'(gi));
      end
   end

   assign head_idx           = head_reg[ROB_IDX_W-1:0];
   assign tail_idx           = tail_reg[ROB_IDX_W-1:0];
   assign full               = (head_idx == tail_idx) &&
                               (head_reg[ROB_IDX_W] != tail_reg[ROB_IDX_W]);
   assign rob_empty          = (head_reg == tail_reg);
   assign head_entry         = entry_reg[head_idx];
   assign commit_int         = head_entry.valid && head_entry.done;
   assign flush_int          = commit_int && head_entry.flush;
   assign dispatch_ready     = !full && !flush_int;
   assign dispatch_fire      = dispatch_valid && dispatch_ready;
   assign dispatch_rob_entry = tail_idx;

   always_comb begin
      commit_valid          = commit_int;
      commit_rd_addr        = head_entry.rd_addr;
      commit_rd_paddr       = head_entry.rd_paddr;
      commit_rob_entry      = head_idx;
      commit_rvfi           = head_entry.rvfi;
      commit_rvfi.pc_wdata  = head_entry.pc_wdata;
      flush                 = flush_int;
      flush_pc              = flush_int ? head_entry.pc_wdata : 32'h0;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_reg <= '0;
         tail_reg <= '0;
         for (int e = 0; e < ROB_DEPTH; e++) begin
            entry_reg[e].valid <= 1'b0;
            entry_reg[e].done  <= 1'b0;
            entry_reg[e].flush <= 1'b0;
         end
      end else if (flush_int) begin
         // Everything younger than the flushing head is squashed.
         head_reg <= ptr_inc(head_reg);
         tail_reg <= ptr_inc(head_reg);
         for (int e = 0; e < ROB_DEPTH; e++) begin
            entry_reg[e].valid <= 1'b0;
            entry_reg[e].done  <= 1'b0;
            entry_reg[e].flush <= 1'b0;
         end
      end else begin
         if (commit_int) begin
            entry_reg[head_idx].valid <= 1'b0;
            entry_reg[head_idx].done  <= 1'b0;
            head_reg                  <= ptr_inc(head_reg);
         end
         if (dispatch_fire) begin
            entry_reg[tail_idx].valid    <= 1'b1;
            entry_reg[tail_idx].done     <= 1'b0;
            entry_reg[tail_idx].flush    <= 1'b0;
            entry_reg[tail_idx].rd_addr  <= dispatch_rd_addr;
            entry_reg[tail_idx].rd_paddr <= dispatch_rd_paddr;
            entry_reg[tail_idx].pc_wdata <= 32'h0;
            entry_reg[tail_idx].rvfi     <= dispatch_rvfi;
            tail_reg                     <= ptr_inc(tail_reg);
         end
         for (int e = 0; e < ROB_DEPTH; e++) begin
            for (int l = 0; l < CDB_SIZE; l++) begin
               if (lane_match[e][l] && entry_reg[e].valid) begin
                  entry_reg[e].done          <= 1'b1;
                  entry_reg[e].flush         <= WB_Bus[l].flush;
                  entry_reg[e].pc_wdata      <= WB_Bus[l].pc_wdata;
                  entry_reg[e].rvfi.rd_wdata <= WB_Bus[l].rd_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer; inputs change and outputs are sampled just
// after the falling edge, so every check sees settled registered state.
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 dispatch_valid;
   logic [4:0]           dispatch_rd_addr;
   logic [PREG_W-1:0]    dispatch_rd_paddr;
   rvfi_t                dispatch_rvfi;
   logic                 dispatch_ready;
   logic [ROB_IDX_W-1:0] dispatch_rob_entry;
   CDB_t                 wb_bus [CDB_SIZE];
   logic                 commit_valid;
   logic [4:0]           commit_rd_addr;
   logic [PREG_W-1:0]    commit_rd_paddr;
   logic [ROB_IDX_W-1:0] commit_rob_entry;
   rvfi_t                commit_rvfi;
   logic                 flush;
   logic [31:0]          flush_pc;
   logic                 rob_empty;

   int total = 0;
   int bad   = 0;

   reorder_buffer dut (
      .clk                (clk),
      .rst                (rst),
      .dispatch_valid     (dispatch_valid),
      .dispatch_rd_addr   (dispatch_rd_addr),
      .dispatch_rd_paddr  (dispatch_rd_paddr),
      .dispatch_rvfi      (dispatch_rvfi),
      .dispatch_ready     (dispatch_ready),
      .dispatch_rob_entry (dispatch_rob_entry),
      .WB_Bus             (wb_bus),
      .commit_valid       (commit_valid),
      .commit_rd_addr     (commit_rd_addr),
      .commit_rd_paddr    (commit_rd_paddr),
      .commit_rob_entry   (commit_rob_entry),
      .commit_rvfi        (commit_rvfi),
      .flush              (flush),
      .flush_pc           (flush_pc),
      .rob_empty          (rob_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic clear_inputs();
      dispatch_valid    = 1'b0;
      dispatch_rd_addr  = '0;
      dispatch_rd_paddr = '0;
      dispatch_rvfi     = '0;
      for (int l = 0; l < CDB_SIZE; l++) wb_bus[l] = '0;
   endtask

   // One clock: inputs set before the call are captured at the rising edge.
   task automatic tick();
      @(negedge clk);
      clear_inputs();
      #1;
   endtask

   task automatic put_disp(input logic [4:0] rd, input logic [PREG_W-1:0] prd, input logic [31:0] pc);
      dispatch_valid          = 1'b1;
      dispatch_rd_addr        = rd;
      dispatch_rd_paddr       = prd;
      dispatch_rvfi           = '0;
      dispatch_rvfi.insn      = 32'h00000013 | {20'h0, rd, 7'h0};
      dispatch_rvfi.pc_rdata  = pc;
      dispatch_rvfi.rd_addr   = rd;
   endtask

   task automatic set_wb(input int lane, input logic [ROB_IDX_W-1:0] idx, input logic [31:0] data,
                         input logic [31:0] pc, input logic fl);
      wb_bus[lane].valid     = 1'b1;
      wb_bus[lane].ROB_entry = idx;
      wb_bus[lane].rd_data   = data;
      wb_bus[lane].pc_wdata  = pc;
      wb_bus[lane].flush     = fl;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   initial begin
      clear_inputs();
      rst            = 1'b0;
      dispatch_valid = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      #1;
      check("rst_empty", rob_empty, 1);
      check("rst_entry", dispatch_rob_entry, 0);
      check("rst_cvalid", commit_valid, 0);
      check("rst_flush", flush, 0);
      check("rst_flush_pc", flush_pc, 0);
      check("rst_ready", dispatch_ready, 1);

      // In-order retire with out-of-order completion 2, 0, 1
      for (int i = 0; i < 3; i++) begin
         put_disp(5'(i + 1), PREG_W'(10 + i), 32'h1000 + 32'(4 * i));
         check("io_disp_idx", dispatch_rob_entry, i);
         tick();
      end
      check("io_not_empty", rob_empty, 0);
      check("io_no_commit", commit_valid, 0);
      set_wb(0, 2, 32'hA2, 32'h100C, 1'b0);
      tick();
      check("io_wait_e0", commit_valid, 0);
      set_wb(0, 0, 32'hA0, 32'h1004, 1'b0);
      check("io_wb_latency", commit_valid, 0);
      tick();
      check("io_c0_valid", commit_valid, 1);
      check("io_c0_idx", commit_rob_entry, 0);
      check("io_c0_wdata", commit_rvfi.rd_wdata, 32'hA0);
      check("io_c0_rd", commit_rd_addr, 1);
      check("io_c0_prd", commit_rd_paddr, 10);
      check("io_c0_pcw", commit_rvfi.pc_wdata, 32'h1004);
      set_wb(0, 1, 32'hA1, 32'h1008, 1'b0);
      tick();
      check("io_c1_valid", commit_valid, 1);
      check("io_c1_idx", commit_rob_entry, 1);
      check("io_c1_wdata", commit_rvfi.rd_wdata, 32'hA1);
      tick();
      check("io_c2_valid", commit_valid, 1);
      check("io_c2_idx", commit_rob_entry, 2);
      check("io_c2_wdata", commit_rvfi.rd_wdata, 32'hA2);
      check("io_c2_rd", commit_rd_addr, 3);
      check("io_c2_pcrd", commit_rvfi.pc_rdata, 32'h1008);
      tick();
      check("io_done_cvalid", commit_valid, 0);
      check("io_done_empty", rob_empty, 1);

      // Full and wrap-around
      do_reset();
      for (int i = 0; i < 16; i++) begin
         check("full_ready_pre", dispatch_ready, 1);
         put_disp(5'(i), PREG_W'(i), 32'h2000 + 32'(4 * i));
         check("full_disp_idx", dispatch_rob_entry, i);
         tick();
      end
      check("full_ready", dispatch_ready, 0);
      check("full_tail_idx", dispatch_rob_entry, 0);
      put_disp(5'd30, 6'd30, 32'hDEAD0000);
      set_wb(0, 0, 32'hB0, 32'h2004, 1'b0);
      tick();
      check("full_c0_valid", commit_valid, 1);
      check("full_c0_idx", commit_rob_entry, 0);
      check("full_c0_rd", commit_rd_addr, 0);
      check("full_still_blocked", dispatch_ready, 0);
      put_disp(5'd9, 6'd9, 32'h3000);
      tick();
      check("wrap_ready", dispatch_ready, 1);
      check("wrap_idx", dispatch_rob_entry, 0);
      check("wrap_no_commit", commit_valid, 0);
      put_disp(5'd20, 6'd40, 32'h3000);
      tick();
      check("wrap_full_again", dispatch_ready, 0);

      // Multi-lane completion
      set_wb(0, 1, 32'hC1, 32'h2008, 1'b0);
      set_wb(1, 2, 32'hC2, 32'h200C, 1'b0);
      tick();
      check("ml_c1_idx", commit_rob_entry, 1);
      check("ml_c1_wdata", commit_rvfi.rd_wdata, 32'hC1);
      tick();
      check("ml_c2_idx", commit_rob_entry, 2);
      check("ml_c2_wdata", commit_rvfi.rd_wdata, 32'hC2);
      set_wb(0, 3, 32'hC3, 32'h2010, 1'b0);
      set_wb(1, 4, 32'hC4, 32'h2014, 1'b0);
      set_wb(2, 5, 32'hC5, 32'h2018, 1'b0);
      tick();
      check("ml_c3_valid", commit_valid, 1);
      check("ml_c3_idx", commit_rob_entry, 3);
      check("ml_c3_wdata", commit_rvfi.rd_wdata, 32'hC3);
      tick();
      check("ml_c4_idx", commit_rob_entry, 4);
      check("ml_c4_wdata", commit_rvfi.rd_wdata, 32'hC4);
      tick();
      check("ml_c5_idx", commit_rob_entry, 5);
      check("ml_c5_wdata", commit_rvfi.rd_wdata, 32'hC5);
      check("ml_c5_pcw", commit_rvfi.pc_wdata, 32'h2018);
      tick();
      check("ml_stall", commit_valid, 0);

      // Mispredict on entry 1 with entries 2-5 in flight
      do_reset();
      for (int i = 0; i < 6; i++) begin
         put_disp(5'(i + 1), PREG_W'(20 + i), 32'h4000 + 32'(4 * i));
         tick();
      end
      set_wb(0, 0, 32'hD0, 32'h4004, 1'b0);
      tick();
      check("mp_c0_valid", commit_valid, 1);
      check("mp_c0_flush", flush, 0);
      check("mp_c0_flush_pc", flush_pc, 0);
      set_wb(1, 1, 32'hD1, 32'h60000040, 1'b1);
      tick();
      check("mp_c1_valid", commit_valid, 1);
      check("mp_c1_idx", commit_rob_entry, 1);
      check("mp_flush", flush, 1);
      check("mp_flush_pc", flush_pc, 32'h60000040);
      check("mp_ready", dispatch_ready, 0);
      put_disp(5'd7, 6'd7, 32'h5000);
      set_wb(0, 3, 32'hD3, 32'h4010, 1'b0);
      tick();
      check("mp_empty", rob_empty, 1);
      check("mp_tail", dispatch_rob_entry, 2);
      check("mp_flush_low", flush, 0);
      check("mp_flush_pc_low", flush_pc, 0);
      check("mp_cvalid_low", commit_valid, 0);
      check("mp_ready_back", dispatch_ready, 1);
      put_disp(5'd8, 6'd8, 32'h6000);
      tick();
      check("mp_redisp_tail", dispatch_rob_entry, 3);
      check("mp_redisp_pending", commit_valid, 0);

      // Reset with 5 valid entries and a commit pending
      for (int i = 0; i < 4; i++) begin
         put_disp(5'(i + 10), PREG_W'(i + 10), 32'h7000 + 32'(4 * i));
         tick();
      end
      set_wb(0, 2, 32'hE2, 32'h6004, 1'b0);
      tick();
      check("mr_pending", commit_valid, 1);
      check("mr_tail", dispatch_rob_entry, 7);
      put_disp(5'd3, 6'd3, 32'h8000);
      do_reset();
      check("mr_empty", rob_empty, 1);
      check("mr_cvalid", commit_valid, 0);
      check("mr_tail0", dispatch_rob_entry, 0);
      check("mr_ready", dispatch_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
